// File: rtl/axi_inval_sequencer.sv
// axi_inval_sequencer: turns accepted AXI INCR write bursts into per-line
// L1 D-cache invalidation requests, dropping back-to-back duplicate lines
// and pulsing done_o per burst in acceptance order.
module axi_inval_sequencer #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned MaxTxns     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [AddrWidth-1:0] burst_addr_i,
    input  logic [7:0]           burst_len_i,
    input  logic [2:0]           burst_size_i,
    input  logic                 burst_valid_i,
    output logic                 burst_ready_o,
    output logic [AddrWidth-1:0] inval_addr_o,
    output logic                 inval_valid_o,
    input  logic                 inval_ready_i,
    output logic                 done_o,
    output logic                 busy_o
);

    localparam int unsigned PtrW = $clog2(MaxTxns);
    localparam logic [AddrWidth-1:0] LineMask = ~(AddrWidth'(L1LineWidth - 1));
    localparam logic [AddrWidth-1:0] LineStep = AddrWidth'(L1LineWidth);

    typedef struct packed {
        logic [AddrWidth-1:0] first;
        logic [AddrWidth-1:0] last;
        logic                 en;
    } desc_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_e;

    desc_t                r_fifo [MaxTxns];
    logic [PtrW:0]        r_wptr, r_rptr;
    state_e               r_state, w_state_nxt;
    logic [AddrWidth-1:0] r_cur, r_end;
    logic [AddrWidth-1:0] r_last_line;
    logic                 r_last_vld;

    logic                 w_empty, w_full, w_push, w_pop;
    logic                 w_suppress, w_valid, w_adv, w_done;
    desc_t                w_head, w_new;
    logic [AddrWidth:0]   w_size_mask, w_bytes, w_end;
    logic [AddrWidth-1:0] w_end_clamp;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                     (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);
    assign w_push  = burst_valid_i && !w_full;
    assign w_head  = r_fifo[r_rptr[PtrW-1:0]];

    // Burst line range at acceptance, one extra bit to catch address-space overflow.
    always_comb begin
        w_size_mask = ((AddrWidth+1)'(1) << burst_size_i) - (AddrWidth+1)'(1);
        w_bytes     = ((AddrWidth+1)'(burst_len_i) + (AddrWidth+1)'(1)) << burst_size_i;
        w_end       = ({1'b0, burst_addr_i} & ~w_size_mask) + w_bytes - (AddrWidth+1)'(1);
        // A burst running past the top of memory stops at the last line, never wraps.
        w_end_clamp = w_end[AddrWidth] ? '1 : w_end[AddrWidth-1:0];
        w_new.first = burst_addr_i & LineMask;
        w_new.last  = w_end_clamp & LineMask;
        w_new.en    = en_i;
    end

    // Descriptor FIFO storage; no reset needed, pointers define occupancy.
    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wptr[PtrW-1:0]] <= w_new;
    end

    // FIFO pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Walker state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Walker next-state and control outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_suppress  = 1'b0;
        w_valid     = 1'b0;
        w_adv       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_head.en ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                // Same line as the last one invalidated: skip with a bubble.
                w_suppress = r_last_vld && (r_cur == r_last_line);
                w_valid    = !w_suppress;
                if (w_suppress || inval_ready_i) begin
                    w_adv = 1'b1;
                    if (r_cur == r_end) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Current/final line of the burst under walk.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cur <= '0;
            r_end <= '0;
        end else if (w_pop) begin
            r_cur <= w_head.first;
            r_end <= w_head.last;
        end else if (w_adv && (r_cur != r_end)) begin
            r_cur <= r_cur + LineStep;
        end
    end

    // Last invalidated line; forgotten whenever coherence is disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_line <= '0;
            r_last_vld  <= 1'b0;
        end else if (!en_i) begin
            r_last_vld  <= 1'b0;
        end else if (w_valid && inval_ready_i) begin
            r_last_line <= r_cur;
            r_last_vld  <= 1'b1;
        end
    end

    assign burst_ready_o = !w_full;
    assign inval_valid_o = w_valid;
    assign inval_addr_o  = w_valid ? r_cur : '0;
    assign done_o        = w_done;
    assign busy_o        = !w_empty || (r_state != S_IDLE);

endmodule
